// File: rtl/serial_loader16.sv
// Serial-to-parallel frame loader.
// Shifts WIDTH data bits in MSB first, optionally checks one trailing
// even-parity bit, then presents the word on out with a single-cycle
// enable strobe for a downstream parallel latch. WIDTH must be at least 2.
module serial_loader16 #(
    parameter int WIDTH     = 16,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] out,
    output logic             enable,
    output logic             busy,
    output logic             perr
);

    // One spare bit so the counter can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STROBE = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sr_q;
    logic [WIDTH-1:0]   sr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   out_q;
    logic               perr_q;
    logic               parity_ok;

    // Shift-register and counter candidates for a cycle that takes a bit.
    always_comb begin
        sr_d      = {sr_q[WIDTH-2:0], sin};
        cnt_d     = cnt_q + CNT_W'(1);
        // Even parity: data bits and parity bit together XOR to zero.
        parity_ok = ((^sr_q) ^ sin) == 1'b0;
    end

    // Frame controller: state, shift register, counter, output word and error flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A bit presented alongside start is deliberately dropped.
                    if (start) begin
                        state_q <= SHIFT;
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        perr_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Idle cycles simply wait; there is no timeout.
                    if (sin_valid) begin
                        sr_q  <= sr_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                            end else begin
                                state_q <= STROBE;
                                out_q   <= sr_d;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (sin_valid) begin
                        if (parity_ok) begin
                            state_q <= STROBE;
                            out_q   <= sr_q;
                        end else begin
                            // Bad frame: keep the previous good word, flag it.
                            state_q <= IDLE;
                            perr_q  <= 1'b1;
                        end
                    end
                end
                STROBE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded purely from the registered state.
    always_comb begin
        enable = (state_q == STROBE);
        busy   = (state_q != IDLE);
        out    = out_q;
        perr   = perr_q;
    end

endmodule

// File: doc/serial_loader16.md
SERIAL_LOADER16 -- requirements
Module: serial_loader16

Interface
REQ-001 Parameter WIDTH, default 16: number of data bits per frame and width of out.
REQ-002 Parameter PARITY_EN, default 1: 1 = each frame carries one trailing even-parity bit; 0 = no parity bit.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  frame start request, honoured only in IDLE.
REQ-007 sin  input  1  serial data bit, MSB first.
REQ-008 sin_valid  input  1  sin is sampled on the edges where sin_valid=1.
REQ-009 out  output  WIDTH  last good assembled word, the data input of the downstream 16-bit latch.
REQ-010 enable  output  1  one-cycle load strobe for the downstream latch.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 perr  output  1  sticky parity-error flag.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, PARITY and STROBE; all outputs SHALL be registered or decoded from state only.
REQ-014 IDLE: start=1 -> SHIFT, clearing the shift register, the bit counter and perr; sin_valid SHALL be ignored.
REQ-015 start and sin_valid high in the same IDLE cycle: start is taken and that bit is discarded.
REQ-016 SHIFT: each cycle with sin_valid=1 SHALL do sr <= {sr[WIDTH-2:0], sin} and count <= count+1; cycles with sin_valid=0 hold all state with no timeout.
REQ-017 SHIFT: when the WIDTH-th bit is taken, next state SHALL be PARITY if PARITY_EN=1, else STROBE.
REQ-018 PARITY: on sin_valid=1, if (XOR of sr) XOR sin = 0 -> STROBE; otherwise perr <= 1 -> IDLE, with out unchanged and no enable pulse.
REQ-019 Loading out: on the edge that enters STROBE, out SHALL load sr.
REQ-020 STROBE: enable=1 for exactly one cycle, then IDLE unconditionally; out is stable while enable=1.
REQ-021 Latency: enable SHALL assert in the cycle immediately after the edge that samples the last bit of the frame (parity bit, or the WIDTH-th data bit if PARITY_EN=0).
REQ-022 start while busy=1 SHALL be ignored and SHALL NOT restart the frame.
REQ-023 out SHALL change only on entry to STROBE or on reset; perr SHALL change only on parity failure, on an accepted start, or on reset.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap within a frame.

Reset
REQ-025 rst=1 at a clock edge SHALL force state=IDLE, out=0, enable=0, busy=0, perr=0, and clear sr and the counter, regardless of state.
REQ-026 rst asserted mid-frame SHALL discard the partial word and produce no enable pulse; the next frame requires a new start.
REQ-027 rst SHALL take priority over start and sin_valid in the same cycle.

Verification
REQ-028 Good frame, PARITY_EN=1: start, then 16 valid bits of 0xA5C3 MSB first, then parity bit 0 -> enable=1 for one cycle the next cycle, out=0xA5C3, perr=0, busy=0 after that cycle.
REQ-029 Bad parity: same frame with parity bit 1 -> no enable pulse, out keeps its previous value, perr=1 until the next accepted start.
REQ-030 Gapped input: 0x0001 with sin_valid deasserted for 3 cycles between every bit, parity 1 -> out=0x0001 and a single enable pulse; busy stays high throughout the gaps.
REQ-031 Reset mid-frame: rst pulsed after 7 bits of 0xFFFF -> all outputs 0 the next cycle; remaining bits without start are ignored and enable stays 0.
REQ-032 start re-asserted during SHIFT after 4 bits of 0x1234 (parity 1) -> ignored, frame completes with out=0x1234.
REQ-033 PARITY_EN=0: start, then 16 bits of 0xFFFF -> enable asserts the cycle after the 16th bit, out=0xFFFF.
